// File: rtl/buffered_uart_pkg.sv
// buffered_uart_pkg: FSM encodings and timing constants for buffered_uart.
// Parity states exist only when BUFFERED_UART_PARITY_EN is defined.
package buffered_uart_pkg;

  localparam int MIN_BIT_PERIOD = 3;
  localparam int SYNC_DEPTH = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef BUFFERED_UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef BUFFERED_UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: first-word fall-through FIFO with registered level.
// Push while full and pop while empty are ignored.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic             do_push;
  logic             do_pop;

  assign full    = level == LVL_W'(DEPTH);
  assign empty   = level == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = empty ? '0 : mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/buffered_uart.sv
// buffered_uart: FIFO-buffered UART with programmable bit period.
// Define BUFFERED_UART_PARITY_EN to add a parity bit and parity error flag.
module buffered_uart
  import buffered_uart_pkg::*;
#(
  parameter int DATA_BITS        = 8,
  parameter int FIFO_DEPTH       = 16,
  parameter int CLOCK_SCALE_BITS = 16,
  parameter int LEVEL_BITS       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CLOCK_SCALE_BITS-1:0] cyclesPerBit,
  input  logic                        txWriteEnable,
  input  logic [DATA_BITS-1:0]        txWriteData,
  output logic                        txFull,
  output logic [LEVEL_BITS-1:0]       txLevel,
  input  logic                        rxReadEnable,
  output logic [DATA_BITS-1:0]        rxReadData,
  output logic                        rxEmpty,
  output logic [LEVEL_BITS-1:0]       rxLevel,
  output logic                        rxOverflow,
  output logic                        rxFrameError,
  input  logic                        clearErrors,
`ifdef BUFFERED_UART_PARITY_EN
  input  logic                        parityOdd,
  output logic                        rxParityError,
`endif
  input  logic                        rx,
  output logic                        tx
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DATA_BITS - 1);

  typedef logic [CLOCK_SCALE_BITS-1:0] cnt_t;

  cnt_t eff_period;
  assign eff_period = (cyclesPerBit < cnt_t'(MIN_BIT_PERIOD)) ?
                      cnt_t'(MIN_BIT_PERIOD) : cyclesPerBit;

  tx_state_t            tx_st, tx_nxt;
  cnt_t                 tx_cnt, tx_period;
  logic [IDX_W-1:0]     tx_idx;
  logic [DATA_BITS-1:0] tx_sh, tx_head;
  logic                 tx_pop, tx_empty, tx_done;

  rx_state_t             rx_st, rx_nxt;
  cnt_t                  rx_cnt, rx_period;
  logic [IDX_W-1:0]      rx_idx;
  logic [DATA_BITS-1:0]  rx_sh;
  logic [SYNC_DEPTH-1:0] rx_sync;
  logic                  rx_s, rx_prev, rx_full;
  logic                  rx_done, rx_half, rx_tick;
  logic                  push_req, ferr_set, ovf_set;

`ifdef BUFFERED_UART_PARITY_EN
  logic tx_par;
  logic perr_set;
`endif

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH), .LVL_W(LEVEL_BITS)) u_txf (
    .clk(clk), .rst(rst),
    .push(txWriteEnable), .wdata(txWriteData), .full(txFull),
    .pop(tx_pop), .rdata(tx_head), .empty(tx_empty), .level(txLevel)
  );

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH), .LVL_W(LEVEL_BITS)) u_rxf (
    .clk(clk), .rst(rst),
    .push(push_req), .wdata(rx_sh), .full(rx_full),
    .pop(rxReadEnable), .rdata(rxReadData), .empty(rxEmpty), .level(rxLevel)
  );

  assign tx_done = tx_cnt == tx_period;

  always_comb begin
    tx_nxt = tx_st;
    tx_pop = 1'b0;
    case (tx_st)
      TX_IDLE: if (!tx_empty) begin
        tx_pop = 1'b1;
        tx_nxt = TX_START;
      end
      TX_START: if (tx_done) tx_nxt = TX_DATA;
`ifdef BUFFERED_UART_PARITY_EN
      TX_DATA: if (tx_done && tx_idx == LAST) tx_nxt = TX_PARITY;
      TX_PARITY: if (tx_done) tx_nxt = TX_STOP;
`else
      TX_DATA: if (tx_done && tx_idx == LAST) tx_nxt = TX_STOP;
`endif
      // Chain straight into the next start bit to avoid an idle gap
      TX_STOP: if (tx_done) begin
        tx_pop = !tx_empty;
        tx_nxt = tx_empty ? TX_IDLE : TX_START;
      end
      default: tx_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st     <= TX_IDLE;
      tx        <= 1'b1;
      tx_cnt    <= '0;
      tx_idx    <= '0;
      tx_sh     <= '0;
      tx_period <= '0;
`ifdef BUFFERED_UART_PARITY_EN
      tx_par    <= 1'b0;
`endif
    end else begin
      tx_st <= tx_nxt;
      if (tx_pop) begin
        tx_sh     <= tx_head;
        tx_cnt    <= '0;
        tx_idx    <= '0;
        tx_period <= eff_period;
        tx        <= 1'b0;
`ifdef BUFFERED_UART_PARITY_EN
        tx_par    <= (^tx_head) ^ parityOdd;
`endif
      end else if (tx_st != TX_IDLE) begin
        tx_cnt <= tx_done ? '0 : tx_cnt + 1'b1;
        if (tx_done) begin
          case (tx_st)
            TX_START: begin
              tx    <= tx_sh[0];
              tx_sh <= tx_sh >> 1;
            end
            TX_DATA: begin
              if (tx_idx == LAST) begin
`ifdef BUFFERED_UART_PARITY_EN
                tx <= tx_par;
`else
                tx <= 1'b1;
`endif
              end else begin
                tx     <= tx_sh[0];
                tx_sh  <= tx_sh >> 1;
                tx_idx <= tx_idx + 1'b1;
              end
            end
            default: tx <= 1'b1;
          endcase
        end
      end
    end
  end

  assign rx_s    = rx_sync[SYNC_DEPTH-1];
  assign rx_done = rx_cnt == rx_period;
  assign rx_half = rx_cnt == (rx_period >> 1);
  assign rx_tick = (rx_st == RX_START) ? rx_half : rx_done;
  assign ovf_set = push_req & rx_full;

  always_comb begin
    rx_nxt   = rx_st;
    push_req = 1'b0;
    ferr_set = 1'b0;
`ifdef BUFFERED_UART_PARITY_EN
    perr_set = 1'b0;
`endif
    case (rx_st)
      RX_IDLE: if (rx_prev && !rx_s) rx_nxt = RX_START;
      RX_START: if (rx_half) rx_nxt = rx_s ? RX_IDLE : RX_DATA;
`ifdef BUFFERED_UART_PARITY_EN
      RX_DATA: if (rx_done && rx_idx == LAST) rx_nxt = RX_PARITY;
      RX_PARITY: if (rx_done) begin
        rx_nxt   = RX_STOP;
        perr_set = rx_s ^ (^rx_sh) ^ parityOdd;
      end
`else
      RX_DATA: if (rx_done && rx_idx == LAST) rx_nxt = RX_STOP;
`endif
      RX_STOP: if (rx_done) begin
        push_req = rx_s;
        ferr_set = !rx_s;
        rx_nxt   = rx_s ? RX_IDLE : RX_WAIT_HIGH;
      end
      RX_WAIT_HIGH: if (rx_s) rx_nxt = RX_IDLE;
      default: rx_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync      <= '1;
      rx_prev      <= 1'b1;
      rx_st        <= RX_IDLE;
      rx_cnt       <= '0;
      rx_idx       <= '0;
      rx_sh        <= '0;
      rx_period    <= '0;
      rxOverflow   <= 1'b0;
      rxFrameError <= 1'b0;
`ifdef BUFFERED_UART_PARITY_EN
      rxParityError <= 1'b0;
`endif
    end else begin
      rx_sync <= {rx_sync[SYNC_DEPTH-2:0], rx};
      rx_prev <= rx_s;
      rx_st   <= rx_nxt;
      // Period tracks the input while idle, so it freezes at the start edge
      if (rx_st == RX_IDLE) begin
        rx_cnt    <= '0;
        rx_idx    <= '0;
        rx_period <= eff_period;
      end else if (rx_tick) begin
        rx_cnt <= '0;
        if (rx_st == RX_DATA) begin
          rx_sh  <= {rx_s, rx_sh[DATA_BITS-1:1]};
          rx_idx <= rx_idx + 1'b1;
        end
      end else begin
        rx_cnt <= rx_cnt + 1'b1;
      end
      rxOverflow   <= (rxOverflow & ~clearErrors) | ovf_set;
      rxFrameError <= (rxFrameError & ~clearErrors) | ferr_set;
`ifdef BUFFERED_UART_PARITY_EN
      rxParityError <= (rxParityError & ~clearErrors) | perr_set;
`endif
    end
  end

endmodule

// File: tb/tb_buffered_uart.sv
// tb_buffered_uart: scenario tasks with a byte scoreboard for buffered_uart.
// Parity scenarios run when BUFFERED_UART_PARITY_EN is defined.
module tb_buffered_uart;

  localparam int DB = 8;
  localparam int BIT = 8;
`ifdef BUFFERED_UART_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME = (2 + DB + P) * BIT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cyclesPerBit = 16'd7;
  logic        txWriteEnable = 1'b0;
  logic [7:0]  txWriteData = 8'h00;
  logic        txFull;
  logic [4:0]  txLevel;
  logic        rxReadEnable = 1'b0;
  logic [7:0]  rxReadData;
  logic        rxEmpty;
  logic [4:0]  rxLevel;
  logic        rxOverflow;
  logic        rxFrameError;
  logic        clearErrors = 1'b0;
`ifdef BUFFERED_UART_PARITY_EN
  logic        parityOdd = 1'b0;
  logic        rxParityError;
`endif
  logic        loop = 1'b0;
  logic        rx_drv = 1'b1;
  logic        rx;
  logic        tx;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic       exp_bits[$];

  assign rx = loop ? tx : rx_drv;

  always #5 clk = ~clk;

  buffered_uart dut (
    .clk(clk), .rst(rst), .cyclesPerBit(cyclesPerBit),
    .txWriteEnable(txWriteEnable), .txWriteData(txWriteData),
    .txFull(txFull), .txLevel(txLevel),
    .rxReadEnable(rxReadEnable), .rxReadData(rxReadData),
    .rxEmpty(rxEmpty), .rxLevel(rxLevel),
    .rxOverflow(rxOverflow), .rxFrameError(rxFrameError),
    .clearErrors(clearErrors),
`ifdef BUFFERED_UART_PARITY_EN
    .parityOdd(parityOdd), .rxParityError(rxParityError),
`endif
    .rx(rx), .tx(tx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic write_byte(input logic [7:0] d);
    txWriteEnable = 1'b1;
    txWriteData = d;
    tick();
    txWriteEnable = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip);
    rx_drv = 1'b0;
    repeat (BIT) tick();
    for (int i = 0; i < DB; i++) begin
      rx_drv = d[i];
      repeat (BIT) tick();
    end
`ifdef BUFFERED_UART_PARITY_EN
    rx_drv = (^d) ^ parityOdd ^ pflip;
    repeat (BIT) tick();
`else
    rx_drv = rx_drv | pflip;
`endif
    rx_drv = stop;
    repeat (BIT) tick();
    rx_drv = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b want 1", tx); end
    checks++; if (txFull !== 1'b0) begin errors++; $display("FAIL rst_txFull: got %b want 0", txFull); end
    checks++; if (rxEmpty !== 1'b1) begin errors++; $display("FAIL rst_rxEmpty: got %b want 1", rxEmpty); end
    checks++; if (txLevel !== 5'd0) begin errors++; $display("FAIL rst_txLevel: got %0d want 0", txLevel); end
    checks++; if (rxLevel !== 5'd0) begin errors++; $display("FAIL rst_rxLevel: got %0d want 0", rxLevel); end
    checks++; if (rxOverflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", rxOverflow); end
    checks++; if (rxFrameError !== 1'b0) begin errors++; $display("FAIL rst_ferr: got %b want 0", rxFrameError); end
    checks++; if (rxReadData !== 8'h00) begin errors++; $display("FAIL rst_rdata: got %h want 00", rxReadData); end
`ifdef BUFFERED_UART_PARITY_EN
    checks++; if (rxParityError !== 1'b0) begin errors++; $display("FAIL rst_perr: got %b want 0", rxParityError); end
`endif
  endtask

  task automatic test_tx_frame();
    logic [7:0] d;
    logic b;
    d = 8'hA5;
    exp_bits = {};
    exp_bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) exp_bits.push_back(d[i]);
`ifdef BUFFERED_UART_PARITY_EN
    exp_bits.push_back((^d) ^ parityOdd);
`endif
    exp_bits.push_back(1'b1);
    write_byte(d);
    checks++; if (txLevel !== 5'd1) begin errors++; $display("FAIL tx_level_n1: got %0d want 1", txLevel); end
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL tx_early: got %b want 1", tx); end
    tick();
    while (exp_bits.size() > 0) begin
      b = exp_bits.pop_front();
      for (int k = 0; k < BIT; k++) begin
        checks++;
        if (tx !== b) begin errors++; $display("FAIL tx_bit: got %b want %b at cycle %0d", tx, b, k); end
        tick();
      end
    end
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL tx_idle_after: got %b want 1", tx); end
    checks++; if (txLevel !== 5'd0) begin errors++; $display("FAIL tx_level_end: got %0d want 0", txLevel); end
  endtask

  task automatic test_loopback();
    logic [7:0] e;
    do_reset();
    loop = 1'b1;
    exp_q = {};
    write_byte(8'h00); exp_q.push_back(8'h00);
    write_byte(8'hFF); exp_q.push_back(8'hFF);
    write_byte(8'h5A); exp_q.push_back(8'h5A);
    for (int i = 0; i < 5 * FRAME && rxLevel != 5'd3; i++) tick();
    checks++; if (rxLevel !== 5'd3) begin errors++; $display("FAIL loop_level: got %0d want 3", rxLevel); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if (rxReadData !== e) begin errors++; $display("FAIL loop_data: got %h want %h", rxReadData, e); end
      rxReadEnable = 1'b1;
      tick();
      rxReadEnable = 1'b0;
    end
    checks++; if (rxEmpty !== 1'b1) begin errors++; $display("FAIL loop_empty: got %b want 1", rxEmpty); end
    checks++; if (rxOverflow !== 1'b0 || rxFrameError !== 1'b0) begin
      errors++; $display("FAIL loop_errs: got ovf=%b ferr=%b want 0 0", rxOverflow, rxFrameError);
    end
    repeat (BIT) tick();
    loop = 1'b0;
  endtask

  task automatic test_back_to_back();
    int rises;
    logic prev;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      txWriteEnable = 1'b1;
      txWriteData = 8'h00;
      if (i == 16) begin
        checks++; if (txFull !== 1'b0) begin errors++; $display("FAIL b2b_notfull: got %b want 0", txFull); end
      end
      if (i == 17) begin
        checks++; if (txFull !== 1'b1) begin errors++; $display("FAIL b2b_full: got %b want 1", txFull); end
        checks++; if (txLevel !== 5'd16) begin errors++; $display("FAIL b2b_level: got %0d want 16", txLevel); end
      end
      tick();
    end
    txWriteEnable = 1'b0;
    checks++; if (txLevel !== 5'd16) begin errors++; $display("FAIL b2b_ignored: got %0d want 16", txLevel); end
    rises = 0;
    prev = tx;
    for (int i = 0; i < 19 * FRAME; i++) begin
      tick();
      if (prev === 1'b0 && tx === 1'b1) rises++;
      prev = tx;
    end
    checks++; if (rises != 17) begin errors++; $display("FAIL b2b_frames: got %0d want 17", rises); end
    checks++; if (txLevel !== 5'd0 || tx !== 1'b1) begin
      errors++; $display("FAIL b2b_drain: got level=%0d tx=%b want 0 1", txLevel, tx);
    end
  endtask

  task automatic test_rx_overflow();
    logic [7:0] d;
    logic [7:0] e;
    do_reset();
    exp_q = {};
    for (int i = 0; i < 17; i++) begin
      d = 8'(i * 29 + 7);
      if (i < 16) exp_q.push_back(d);
      send_frame(d, 1'b1, 1'b0);
    end
    checks++; if (rxLevel !== 5'd16) begin errors++; $display("FAIL ovf_level: got %0d want 16", rxLevel); end
    checks++; if (rxOverflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", rxOverflow); end
    checks++; if (rxFrameError !== 1'b0) begin errors++; $display("FAIL ovf_ferr: got %b want 0", rxFrameError); end
    clearErrors = 1'b1;
    tick();
    clearErrors = 1'b0;
    checks++; if (rxOverflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", rxOverflow); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if (rxReadData !== e) begin errors++; $display("FAIL ovf_data: got %h want %h", rxReadData, e); end
      rxReadEnable = 1'b1;
      tick();
      rxReadEnable = 1'b0;
    end
    checks++; if (rxEmpty !== 1'b1) begin errors++; $display("FAIL ovf_empty: got %b want 1", rxEmpty); end
  endtask

  task automatic test_frame_error();
    logic [7:0] e;
    send_frame(8'h33, 1'b0, 1'b0);
    repeat (20) tick();
    rx_drv = 1'b0;
    tick();
    rx_drv = 1'b1;
    repeat (40) tick();
    checks++; if (rxFrameError !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b want 1", rxFrameError); end
    checks++; if (rxLevel !== 5'd0) begin errors++; $display("FAIL ferr_level: got %0d want 0", rxLevel); end
    checks++; if (rxOverflow !== 1'b0) begin errors++; $display("FAIL ferr_ovf: got %b want 0", rxOverflow); end
    exp_q.push_back(8'h6C);
    send_frame(8'h6C, 1'b1, 1'b0);
    e = exp_q.pop_front();
    checks++; if (rxLevel !== 5'd1) begin errors++; $display("FAIL ferr_next_level: got %0d want 1", rxLevel); end
    checks++; if (rxReadData !== e) begin errors++; $display("FAIL ferr_next_data: got %h want %h", rxReadData, e); end
    rxReadEnable = 1'b1;
    tick();
    rxReadEnable = 1'b0;
  endtask

  task automatic test_reset_midframe();
    do_reset();
    send_frame(8'h99, 1'b1, 1'b0);
    write_byte(8'hA5);
    write_byte(8'h3C);
    write_byte(8'hC3);
    repeat (20) tick();
    checks++; if (txLevel !== 5'd2) begin errors++; $display("FAIL mid_txlevel: got %0d want 2", txLevel); end
    checks++; if (rxLevel !== 5'd1) begin errors++; $display("FAIL mid_rxlevel: got %0d want 1", rxLevel); end
    rst = 1'b1;
    tick();
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL mid_tx: got %b want 1", tx); end
    checks++; if (txLevel !== 5'd0) begin errors++; $display("FAIL mid_txflush: got %0d want 0", txLevel); end
    checks++; if (rxLevel !== 5'd0 || rxEmpty !== 1'b1) begin
      errors++; $display("FAIL mid_rxflush: got level=%0d empty=%b want 0 1", rxLevel, rxEmpty);
    end
    rst = 1'b0;
    repeat (30) tick();
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL mid_quiet: got %b want 1", tx); end
  endtask

`ifdef BUFFERED_UART_PARITY_EN
  task automatic test_parity();
    do_reset();
    parityOdd = 1'b1;
    write_byte(8'h01);
    tick();
    repeat (9 * BIT + 4) tick();
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL par_txbit: got %b want 0", tx); end
    repeat (2 * BIT) tick();
    send_frame(8'h3C, 1'b1, 1'b1);
    checks++; if (rxLevel !== 5'd1) begin errors++; $display("FAIL par_level: got %0d want 1", rxLevel); end
    checks++; if (rxReadData !== 8'h3C) begin errors++; $display("FAIL par_data: got %h want 3c", rxReadData); end
    checks++; if (rxParityError !== 1'b1) begin errors++; $display("FAIL par_flag: got %b want 1", rxParityError); end
    clearErrors = 1'b1;
    tick();
    clearErrors = 1'b0;
    checks++; if (rxParityError !== 1'b0) begin errors++; $display("FAIL par_clear: got %b want 0", rxParityError); end
    parityOdd = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_tx_frame();
    test_loopback();
    test_back_to_back();
    test_rx_overflow();
    test_frame_error();
    test_reset_midframe();
`ifdef BUFFERED_UART_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/buffered_uart.md
# buffered_uart

Parametrised, FIFO-buffered UART port: next generation of the simulation/SoC UART wrapper. Adds configurable data width, TX and RX FIFOs, a runtime-programmable bit period, and sticky error reporting (overflow, framing, optional parity). It sits between a core-side register/bus adapter and the `rx`/`tx` pins, and is also used directly by testbenches as a fast host-side UART model.

## Interface
- `DATA_BITS`, 8: data bits per frame; legal range 5–9.
- `FIFO_DEPTH`, 16: entries per FIFO; power of two, ≥2.
- `CLOCK_SCALE_BITS`, 16: width of `cyclesPerBit`.
- `LEVEL_BITS`, `$clog2(FIFO_DEPTH)+1`: width of the level outputs; derived, do not override.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset; synchronous, active-high.
- `cyclesPerBit` in CLOCK_SCALE_BITS: bit period minus one, in `clk` cycles. Values <3 are treated as 3.
- `txWriteEnable` in 1: push `txWriteData` into the TX FIFO.
- `txWriteData` in DATA_BITS: byte to transmit.
- `txFull` out 1: TX FIFO full.
- `txLevel` out LEVEL_BITS: TX FIFO occupancy.
- `rxReadEnable` in 1: pop the RX FIFO head.
- `rxReadData` out DATA_BITS: RX FIFO head (first-word fall-through).
- `rxEmpty` out 1: RX FIFO empty.
- `rxLevel` out LEVEL_BITS: RX FIFO occupancy.
- `rxOverflow` out 1: sticky; a frame was dropped because the RX FIFO was full.
- `rxFrameError` out 1: sticky; a stop bit was sampled low.
- `clearErrors` in 1: clears all sticky error flags.
- `rx` in 1: serial input, asynchronous.
- `tx` out 1: serial output, idle high.

## Operation
- Reset values: `tx`=1; `txFull`=0; `rxEmpty`=1; both levels=0; all errors=0; `rxReadData`=0. Reset mid-frame aborts the frame (`tx` high on the next cycle) and flushes both FIFOs.
- Frame format: 1 start bit (0), then DATA_BITS data bits LSB first, then the parity bit if enabled, then 1 stop bit (1). Every bit lasts `cyclesPerBit+1` cycles.
- `cyclesPerBit` is latched at frame start; changing it mid-frame has no effect until the next frame.
- TX FSM: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - In IDLE with the FIFO non-empty, the engine pops the head into its shift register and enters START.
  - Back-to-back frames leave no idle gap.
- RX input: `rx` passes through a 2-flop synchroniser before use.
- RX FSM: IDLE → START → DATA → [PARITY] → STOP → (WAIT_HIGH) → IDLE.
  - A falling edge in IDLE enters START.
  - START waits `cyclesPerBit>>1` cycles, then checks the line. If it is high, the event is a glitch: return to IDLE, nothing stored.
  - Each later bit is sampled at mid-bit, i.e. `cyclesPerBit+1` cycles after the previous sample.
  - STOP sampled high: push the byte. If the FIFO is full, drop the byte and set `rxOverflow`.
  - STOP sampled low: set `rxFrameError`, discard the byte, and wait in WAIT_HIGH until the line is high.
- FIFO boundaries:
  - Write while `txFull` is ignored. `txFull` is evaluated before any same-cycle pop.
  - Read while `rxEmpty` is ignored and the head is unchanged.
  - Simultaneous push and pop on a non-empty, non-full FIFO: level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags: `clearErrors` clears all of them. If a new error is set in the same cycle as `clearErrors`, the set wins.

## Timing
- TX latency: write at cycle N with the engine idle and the FIFO empty → `txLevel`=1 at N+1 → pop at N+1 → `tx` falls at N+2.
- Frame length: (2+DATA_BITS+P)·(`cyclesPerBit`+1) cycles, where P=1 with parity enabled, else 0.
- RX latency: stop-bit sample at cycle M (synchroniser delay included in the sampling point) → `rxEmpty` low and the level updated at M+1.
- Level outputs are registered and change one cycle after the push/pop edge.

## Configuration
- `BUFFERED_UART_PARITY_EN` defined:
  - Adds input `parityOdd` (1: odd parity, 0: even parity) and sticky output `rxParityError`.
  - TX inserts a parity bit; RX checks it.
  - On a parity mismatch the byte is still pushed and `rxParityError` is set.
  - `clearErrors` also clears `rxParityError`.
- Not defined: no parity state in either FSM, no extra ports, P=0.

## Structure
- Package `buffered_uart_pkg`: TX/RX FSM state encodings, the minimum-bit-period constant (3), and the synchroniser depth (2).
- One sub-module, `uart_sync_fifo`:
  - Parametrised by width and depth.
  - Provides first-word fall-through, full/empty flags and level.
  - Instantiated twice, once for TX and once for RX.
- The TX and RX engines stay inline in `buffered_uart`.

## Test plan
All scenarios use DATA_BITS=8, FIFO_DEPTH=16, `cyclesPerBit`=7.
- Write 0xA5 at idle → `tx` falls at N+2. Each bit lasts 8 cycles: 0 (start), 1,0,1,0,0,1,0,1 (data), 1 (stop). Total frame 80 cycles.
- Loop `tx` to `rx`; write 0x00, 0xFF, 0x5A → `rxLevel`=3 and three reads return 0x00, 0xFF, 0x5A in order. No error flags set.
- Write 18 bytes back-to-back from idle → `txFull`=1 after the 17th write, the 18th write is ignored, and exactly 17 frames are transmitted.
- Drive 17 valid frames with no reads → `rxLevel`=16 and `rxOverflow`=1. The FIFO holds frames 1–16. A `clearErrors` pulse clears `rxOverflow`.
- Drive a frame with the stop bit low, then a 1-cycle low glitch → `rxFrameError`=1, `rxLevel` unchanged, and the glitch is ignored.
- Configuration and reset:
  - With the macro defined and `parityOdd`=1, sending 0x01 produces parity bit 0.
  - RX with a flipped parity bit → byte stored and `rxParityError`=1.
  - `rst` asserted mid-frame → `tx`=1 the next cycle and both levels = 0.
